// File: rtl/rv_pkg.sv
// Shared register-file writeback definitions.
package rv_pkg;

  localparam int REG_AW = 5;
  localparam int XLEN   = 32;
  localparam logic [REG_AW-1:0] X0 = '0;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order buffer of pending memory writebacks, with per-entry rd/valid
// exposed so the hazard logic can see every outstanding destination.
module wb_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [REG_AW-1:0]             push_rd,
  input  logic [XLEN-1:0]               push_data,
  input  logic                          pop,
  output wb_entry_t                     head,
  output logic [AW:0]                   count,
  output logic [DEPTH-1:0]              entry_valid,
  output logic [DEPTH-1:0][REG_AW-1:0]  entry_rd
);

  wb_entry_t       entries [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  assign head = entries[rd_ptr];

  // Flatten entry fields for the hazard comparators in the top level.
  always_comb begin
    entry_valid = '0;
    entry_rd    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i] = entries[i].valid;
      entry_rd[i]    = entries[i].rd;
    end
  end

  // Pointer, count and storage update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (pop) begin
        entries[rd_ptr].valid <= 1'b0;
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push) begin
        entries[wr_ptr] <= '{valid: 1'b1, rd: push_rd, data: push_data};
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + (AW+1)'(1);
      end else if (pop && !push) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Merges unstallable ALU results and buffered memory results onto the single
// register-file write port, and flags decode operands with pending writes.
module wb_write_arbiter
  import rv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_data,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output logic              hazard_rs1,
  output logic              hazard_rs2,
  output logic              RegWrite,
  output logic [REG_AW-1:0] Rd,
  output logic [XLEN-1:0]   Write_data
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  wb_entry_t                    head;
  logic [AW:0]                  count;
  logic [DEPTH-1:0]             entry_valid;
  logic [DEPTH-1:0][REG_AW-1:0] entry_rd;

  logic alu_write;
  logic mem_push;
  logic fifo_pop;

  // Writes to x0 are dropped on both paths; a memory x0 result is still
  // handshaken so the source is not blocked.
  assign mem_ready = (count != FULL_COUNT);
  assign alu_write = alu_valid && (alu_rd != X0);
  assign mem_push  = mem_valid && mem_ready && (mem_rd != X0);
  assign fifo_pop  = !alu_write && (count != '0);

  wb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (mem_push),
    .push_rd     (mem_rd),
    .push_data   (mem_data),
    .pop         (fifo_pop),
    .head        (head),
    .count       (count),
    .entry_valid (entry_valid),
    .entry_rd    (entry_rd)
  );

  // Output register: ALU wins, otherwise drain the FIFO head, otherwise idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWrite   <= 1'b0;
      Rd         <= '0;
      Write_data <= '0;
    end else if (alu_write) begin
      RegWrite   <= 1'b1;
      Rd         <= alu_rd;
      Write_data <= alu_data;
    end else if (fifo_pop) begin
      RegWrite   <= 1'b1;
      Rd         <= head.rd;
      Write_data <= head.data;
    end else begin
      RegWrite   <= 1'b0;
    end
  end

  // A source is hazardous while it is buffered or sitting in the output
  // register that the register file has not yet latched.
  always_comb begin
    hazard_rs1 = 1'b0;
    hazard_rs2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && entry_rd[i] == rs1) hazard_rs1 = 1'b1;
      if (entry_valid[i] && entry_rd[i] == rs2) hazard_rs2 = 1'b1;
    end
    if (RegWrite && Rd == rs1) hazard_rs1 = 1'b1;
    if (RegWrite && Rd == rs2) hazard_rs2 = 1'b1;
    if (rs1 == X0) hazard_rs1 = 1'b0;
    if (rs2 == X0) hazard_rs2 = 1'b0;
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, compared
// against a queue-based reference model of the writeback port.
module tb_wb_write_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [4:0]  mem_rd = '0;
  logic [31:0] mem_data = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic        hazard_rs1;
  logic        hazard_rs2;
  logic        RegWrite;
  logic [4:0]  Rd;
  logic [31:0] Write_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic        m_rw;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;

  wb_write_arbiter #(.DEPTH(DEPTH), .AW(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .rs1        (rs1),
    .rs2        (rs2),
    .hazard_rs1 (hazard_rs1),
    .hazard_rs2 (hazard_rs2),
    .RegWrite   (RegWrite),
    .Rd         (Rd),
    .Write_data (Write_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic hazardExp(input logic [4:0] rs);
    if (rs == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].rd == rs) return 1'b1;
    return m_rw && (m_rd == rs);
  endfunction

  function automatic logic modelReady();
    return mq.size() != DEPTH;
  endfunction

  // One clock cycle: drive inputs, check combinational outputs, advance the
  // model across the edge, then check the registered write port.
  task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                               input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                               input logic [4:0] s1, input logic [4:0] s2);
    logic acc;
    logic aw;
    ent_t h;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    rs1 = s1; rs2 = s2;
    #1;
    checkOutput("mem_ready", 32'(mem_ready), 32'(modelReady()));
    checkOutput("hazard_rs1", 32'(hazard_rs1), 32'(hazardExp(s1)));
    checkOutput("hazard_rs2", 32'(hazard_rs2), 32'(hazardExp(s2)));
    acc = mv && modelReady();
    aw  = av && (ard != 5'd0);
    if (aw) begin
      m_rw = 1'b1; m_rd = ard; m_wd = ad;
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      m_rw = 1'b1; m_rd = h.rd; m_wd = h.data;
    end else begin
      m_rw = 1'b0;
    end
    if (acc && mrd != 5'd0) mq.push_back('{rd: mrd, data: md});
    @(posedge clk);
    #1;
    checkOutput("RegWrite", 32'(RegWrite), 32'(m_rw));
    checkOutput("Rd", 32'(Rd), 32'(m_rd));
    checkOutput("Write_data", Write_data, m_wd);
  endtask

  task automatic idleCycle(input logic [4:0] s1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, s1, 5'd0);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic doReset();
    reset = 1'b1;
    alu_valid = 1'b0; mem_valid = 1'b0;
    #1;
    checkOutput("rst_RegWrite", 32'(RegWrite), 32'd0);
    checkOutput("rst_Rd", 32'(Rd), 32'd0);
    checkOutput("rst_Write_data", Write_data, 32'd0);
    mq.delete();
    m_rw = 1'b0; m_rd = '0; m_wd = '0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_mem_ready", 32'(mem_ready), 32'd1);
  endtask

  initial begin
    int idx;
    m_rw = 1'b0; m_rd = '0; m_wd = '0;
    @(posedge clk);
    #1;
    doReset();

    // Reset mid-stream with three buffered entries; nothing stale afterwards.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 5'd20 + 5'(i), 32'hA000 + i, 1'b1, 5'd3 + 5'(i), 32'hB000 + i, 5'd3, 5'd4);
    doReset();
    for (int i = 0; i < 3; i++) idleCycle(5'd3);

    // ALU write latency and x0 suppression.
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    applyStimulus(1'b1, 5'd0, 32'hCAFEF00D, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    checkOutput("alu_x0_nowrite", 32'(RegWrite), 32'd0);

    // Single memory writeback: two-cycle latency, hazard window on rs1=7.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd0);
    checkOutput("mem_lat_n1", 32'(RegWrite), 32'd0);
    checkOutput("haz_after_accept", 32'(hazard_rs1), 32'd1);
    idleCycle(5'd7);
    checkOutput("mem_lat_n2", 32'(RegWrite), 32'd1);
    checkOutput("mem_lat_rd", 32'(Rd), 32'd7);
    idleCycle(5'd7);
    idleCycle(5'd7);
    checkOutput("haz_cleared", 32'(hazard_rs1), 32'd0);

    // Continuous ALU traffic starves the FIFO until it backpressures.
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      logic ready_now;
      ready_now = modelReady();
      applyStimulus(1'b1, 5'd1 + 5'(i), 32'h100 + i, idx < 5, 5'd10 + 5'(idx), 32'h200 + idx, 5'd13, 5'd10);
      if (idx < 5 && ready_now) idx++;
    end
    checkOutput("starve_accepted", 32'(idx), 32'd4);
    #1;
    checkOutput("starve_full", 32'(mem_ready), 32'd0);
    for (int i = 0; i < 6; i++) idleCycle(5'd12);

    // Push and pop together at DEPTH-1 entries so the write pointer wraps.
    doReset();
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd16 + 5'(i), 32'h300 + i, 5'd16, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd19, 32'h303, 5'd19, 5'd18);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd21, 32'h304, 5'd21, 5'd0);
    for (int i = 0; i < 6; i++) idleCycle(5'd21);

    // Memory result to x0: handshaken, never written, no hazard.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55AA55AA, 5'd0, 5'd0);
    idleCycle(5'd0);
    checkOutput("mem_x0_nowrite", 32'(RegWrite), 32'd0);

    // Random traffic with a narrow register range to exercise hazards.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 99) < 40), 5'($urandom_range(0, 7)), $urandom,
                    ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 8; i++) idleCycle(5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
